// File: rtl/miss_block_streamer.sv
`default_nettype none
// miss_block_streamer: captures a refilled cache block and streams its words
// critical-word-first (or only the missed word) over a valid/ready handshake.
module miss_block_streamer #(
  parameter int WORD_WIDTH = 20,
  parameter int NUM_WORDS  = 16,
  parameter int STREAM_ALL = 1,
  localparam int OFF_W          = $clog2(NUM_WORDS),
  localparam int MEM_DATA_WIDTH = WORD_WIDTH * NUM_WORDS
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic [MEM_DATA_WIDTH-1:0] i_mem_data,
  input  logic [OFF_W-1:0]          i_block_offset_bits,
  input  logic                      i_valid,
  output logic                      o_ready,
  output logic [WORD_WIDTH-1:0]     o_word,
  output logic [OFF_W-1:0]          o_word_offset,
  output logic                      o_critical,
  output logic                      o_last,
  output logic                      o_valid,
  input  logic                      i_ready
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam logic [OFF_W-1:0] LAST_COUNT = OFF_W'(NUM_WORDS - 1);

  state_t                    state;
  logic [MEM_DATA_WIDTH-1:0] data_q;
  logic [OFF_W-1:0]          start_q;
  logic [OFF_W-1:0]          count_q;
  logic [OFF_W-1:0]          sel;
  logic                      streaming;
  logic                      last_beat;

  // Offset arithmetic wraps naturally in OFF_W bits, giving the critical-word-first order.
  assign streaming = (state == STREAM);
  assign sel       = start_q + count_q;
  assign last_beat = (STREAM_ALL == 0) || (count_q == LAST_COUNT);

  assign o_ready       = i_rstn && !streaming;
  assign o_valid       = streaming;
  assign o_word        = streaming ? data_q[sel*WORD_WIDTH +: WORD_WIDTH] : '0;
  assign o_word_offset = streaming ? sel : '0;
  assign o_critical    = streaming && (count_q == '0);
  assign o_last        = streaming && last_beat;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state   <= IDLE;
      data_q  <= '0;
      start_q <= '0;
      count_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            data_q  <= i_mem_data;
            start_q <= i_block_offset_bits;
            count_q <= '0;
            state   <= STREAM;
          end
        end
        STREAM: begin
          if (i_ready) begin
            if (last_beat) begin
              state <= IDLE;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_miss_block_streamer.sv
`default_nettype none
// tb_miss_block_streamer: scoreboard bench for the full-block and single-word streamer variants.
module tb_miss_block_streamer;

  logic         clk;
  logic         rstn;
  logic [319:0] mem_data;
  logic [3:0]   off;
  logic         valid, ready_in;
  logic         ready_out, crit, last, ovalid;
  logic [19:0]  word;
  logic [3:0]   word_off;

  logic         valid1, ready1;
  logic         ready_out1, crit1, last1, ovalid1;
  logic [19:0]  word1;
  logic [3:0]   word_off1;

  typedef struct packed {
    logic [19:0] w;
    logic [3:0]  o;
    logic        c;
    logic        l;
  } beat_t;

  beat_t sb[$];
  int tests = 0;
  int fails = 0;

  miss_block_streamer dut (
    .i_clk(clk), .i_rstn(rstn), .i_mem_data(mem_data), .i_block_offset_bits(off),
    .i_valid(valid), .o_ready(ready_out), .o_word(word), .o_word_offset(word_off),
    .o_critical(crit), .o_last(last), .o_valid(ovalid), .i_ready(ready_in)
  );

  miss_block_streamer #(.STREAM_ALL(0)) dut1 (
    .i_clk(clk), .i_rstn(rstn), .i_mem_data(mem_data), .i_block_offset_bits(off),
    .i_valid(valid1), .o_ready(ready_out1), .o_word(word1), .o_word_offset(word_off1),
    .o_critical(crit1), .o_last(last1), .o_valid(ovalid1), .i_ready(ready1)
  );

  always #5 clk = ~clk;

  function automatic logic [319:0] mem_block();
    logic [319:0] m;
    for (int k = 0; k < 16; k++) m[k*20 +: 20] = 20'(k + 1);
    return m;
  endfunction

  function automatic void push_block(input int start, input int nbeats);
    beat_t b;
    for (int c = 0; c < nbeats; c++) begin
      b.o = 4'((start + c) % 16);
      b.w = 20'(((start + c) % 16) + 1);
      b.c = (c == 0);
      b.l = (c == nbeats - 1);
      sb.push_back(b);
    end
  endfunction

  // Captures a block at the next falling edge, then consumes up to max_beats beats.
  task automatic run_stream(input int start, input bit rnd, input bit scram,
                            input int max_beats, input bit keep_valid);
    beat_t exp, held;
    bit    stalled;
    int    got;
    stalled = 0;
    got     = 0;
    @(negedge clk);
    tests++;
    if (ready_out !== 1'b1 || ovalid !== 1'b0) begin
      fails++;
      $display("FAIL capture_idle: o_ready=%b o_valid=%b, required 1/0", ready_out, ovalid);
    end
    mem_data = mem_block();
    off      = 4'(start);
    valid    = 1'b1;
    ready_in = 1'b0;
    push_block(start, 16);
    @(negedge clk);
    if (!keep_valid) valid = 1'b0;
    else off = 4'(start + 4);
    for (int cyc = 0; cyc < 200 && got < max_beats; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (scram) begin
        mem_data = {10{$urandom()}};
        off      = 4'($urandom_range(0, 15));
      end
      ready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tests++;
      if (ovalid !== 1'b1 || ready_out !== 1'b0) begin
        fails++;
        $display("FAIL stream_valid: o_valid=%b o_ready=%b, required 1/0", ovalid, ready_out);
      end
      if (stalled) begin
        tests++;
        if ({word, word_off, crit, last} !== held) begin
          fails++;
          $display("FAIL stall_stable: got %h, held %h", {word, word_off, crit, last}, held);
        end
      end
      if (ready_in) begin
        exp = sb.pop_front();
        tests++;
        if ({word, word_off, crit, last} !== exp) begin
          fails++;
          $display("FAIL beat: word=%0d off=%0d crit=%b last=%b, required word=%0d off=%0d crit=%b last=%b",
                   word, word_off, crit, last, exp.w, exp.o, exp.c, exp.l);
        end
        got++;
        stalled = 0;
      end else begin
        held    = {word, word_off, crit, last};
        stalled = 1;
      end
    end
    tests++;
    if (got < max_beats) begin
      fails++;
      $display("FAIL stream_timeout: beats=%0d, required %0d", got, max_beats);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({ovalid, ready_out, word, word_off, crit, last} !== '0 || ovalid1 !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: valid=%b ready=%b word=%0d off=%0d crit=%b last=%b, required all 0",
               ovalid, ready_out, word, word_off, crit, last);
    end
    rstn = 1'b1;
    @(negedge clk);
    tests++;
    if (ready_out !== 1'b1 || ovalid !== 1'b0 || ready_out1 !== 1'b1) begin
      fails++;
      $display("FAIL reset_release: o_ready=%b o_valid=%b, required 1/0", ready_out, ovalid);
    end
  endtask

  task automatic test_end_idle(input string name);
    @(negedge clk);
    tests++;
    if (ovalid !== 1'b0 || ready_out !== 1'b1 || sb.size() != 0) begin
      fails++;
      $display("FAIL %s_idle: o_valid=%b o_ready=%b pending=%0d, required 0/1/0",
               name, ovalid, ready_out, sb.size());
    end
  endtask

  task automatic test_basic();
    run_stream(5, 0, 0, 16, 0);
    test_end_idle("basic");
  endtask

  task automatic test_wrap();
    run_stream(15, 0, 0, 16, 0);
    test_end_idle("wrap");
  endtask

  task automatic test_single_word();
    beat_t exp;
    @(negedge clk);
    mem_data = mem_block();
    off      = 4'd9;
    valid1   = 1'b1;
    ready1   = 1'b1;
    push_block(9, 1);
    tests++;
    if (ready_out1 !== 1'b1) begin
      fails++;
      $display("FAIL single_capture: o_ready=%b, required 1", ready_out1);
    end
    @(negedge clk);
    valid1 = 1'b0;
    exp    = sb.pop_front();
    tests++;
    if (ovalid1 !== 1'b1 || {word1, word_off1, crit1, last1} !== exp) begin
      fails++;
      $display("FAIL single_beat: valid=%b word=%0d off=%0d crit=%b last=%b, required 1 word=%0d off=%0d crit=%b last=%b",
               ovalid1, word1, word_off1, crit1, last1, exp.w, exp.o, exp.c, exp.l);
    end
    @(negedge clk);
    tests++;
    if (ovalid1 !== 1'b0 || ready_out1 !== 1'b1) begin
      fails++;
      $display("FAIL single_idle: o_valid=%b o_ready=%b, required 0/1", ovalid1, ready_out1);
    end
  endtask

  task automatic test_backpressure();
    run_stream(5, 1, 1, 16, 0);
    test_end_idle("backpressure");
  endtask

  task automatic test_reset_midstream();
    run_stream(5, 0, 0, 3, 0);
    @(negedge clk);
    rstn     = 1'b0;
    ready_in = 1'b0;
    @(negedge clk);
    tests++;
    if ({ovalid, ready_out, word, word_off, crit, last} !== '0) begin
      fails++;
      $display("FAIL midreset_outputs: valid=%b ready=%b word=%0d off=%0d, required all 0",
               ovalid, ready_out, word, word_off);
    end
    rstn = 1'b1;
    sb.delete();
    run_stream(0, 0, 0, 16, 0);
    test_end_idle("midreset");
  endtask

  task automatic test_valid_held();
    run_stream(3, 0, 0, 16, 1);
    run_stream(11, 0, 0, 16, 0);
    test_end_idle("valid_held");
  endtask

  initial begin
    clk      = 1'b0;
    rstn     = 1'b0;
    mem_data = '0;
    off      = '0;
    valid    = 1'b0;
    ready_in = 1'b0;
    valid1   = 1'b0;
    ready1   = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_single_word();
    test_backpressure();
    test_reset_midstream();
    test_valid_held();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/miss_block_streamer.md
MISS_BLOCK_STREAMER -- requirements
Module: miss_block_streamer

Interface
REQ-001 Parameter WORD_WIDTH, default 20: bits per instruction word.
REQ-002 Parameter NUM_WORDS, default 16: words per cache block. SHALL be a power of two and at least 2.
REQ-003 Parameter STREAM_ALL, default 1: 1 streams the whole block critical-word-first; 0 emits only the missed word.
REQ-004 Localparam OFF_W = $clog2(NUM_WORDS); localparam MEM_DATA_WIDTH = WORD_WIDTH*NUM_WORDS.
REQ-005 i_clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 i_rstn  in  1  synchronous active-low reset.
REQ-007 i_mem_data  in  MEM_DATA_WIDTH  refilled block; word k occupies bits [k*WORD_WIDTH +: WORD_WIDTH].
REQ-008 i_block_offset_bits  in  OFF_W  offset of the missed word.
REQ-009 i_valid  in  1  block and offset valid.
REQ-010 o_ready  out  1  block accepted this cycle when i_valid=1.
REQ-011 o_word  out  WORD_WIDTH  streamed word.
REQ-012 o_word_offset  out  OFF_W  block offset of o_word.
REQ-013 o_critical  out  1  o_word is the missed word.
REQ-014 o_last  out  1  o_word is the final word of this block.
REQ-015 o_valid  out  1  o_word and its qualifiers valid.
REQ-016 i_ready  in  1  downstream accepts o_word this cycle.

Function
REQ-017 The FSM SHALL have two states: IDLE and STREAM.
REQ-018 o_ready SHALL be 1 only in IDLE with i_rstn=1, and 0 in STREAM.
REQ-019 Capture: on i_valid=1 and o_ready=1, the block SHALL register i_mem_data and i_block_offset_bits as start, clear the beat counter, and enter STREAM on the next edge.
REQ-020 Latency: o_valid SHALL rise in the cycle after capture, one clock.
REQ-021 In STREAM, o_valid=1 and the selected offset SHALL be (start + count) mod NUM_WORDS, with natural OFF_W-bit wrap.
REQ-022 o_word SHALL be the captured word at the selected offset, and o_word_offset SHALL equal that offset.
REQ-023 o_critical SHALL be 1 only when count=0.
REQ-024 o_last SHALL be 1 when STREAM_ALL=0, or when count=NUM_WORDS-1.
REQ-025 Handshake: a beat transfers when o_valid=1 and i_ready=1.
REQ-026 On a transfer with o_last=0, count SHALL increment.
REQ-027 On a transfer with o_last=1, the FSM SHALL return to IDLE, with o_valid=0 and o_ready=1 next cycle.
REQ-028 Backpressure: while o_valid=1 and i_ready=0, o_word, o_word_offset, o_critical and o_last SHALL hold stable.
REQ-029 Changes on i_mem_data or i_block_offset_bits after capture SHALL NOT affect the stream in progress.
REQ-030 i_valid during STREAM SHALL be ignored; no capture and no queueing.
REQ-031 Each block SHALL yield exactly NUM_WORDS beats (STREAM_ALL=1) or exactly 1 beat (STREAM_ALL=0), each offset exactly once.
REQ-032 Outputs SHALL be register-driven or decoded from registered state only, with no combinational path from i_ready to o_valid.

Reset
REQ-033 i_rstn=0 at a clock edge SHALL force IDLE, clear count, start and the captured data to 0, and set o_valid, o_critical and o_last to 0.
REQ-034 With i_rstn=0, o_word and o_word_offset SHALL be 0, and o_ready SHALL be 0.
REQ-035 Reset asserted mid-stream SHALL abort the stream; no further beats are emitted, and o_ready=1 in the first cycle after i_rstn returns to 1.

Verification
REQ-036 Scenario: defaults, word k = k+1, offset 5, i_ready tied 1 -> 16 beats on consecutive cycles; offsets 5..15 then 0..4; words 6..16 then 1..5; o_critical on beat 1 only; o_last on beat 16 only.
REQ-037 Scenario: offset 15 -> first beat offset 15 and word 16; second beat offset 0 and word 1 (wrap); o_last on offset 14.
REQ-038 Scenario: STREAM_ALL=0, offset 9 -> one beat, word 10 with o_critical=1 and o_last=1; o_ready=1 on the following cycle.
REQ-039 Scenario: i_ready toggled pseudo-randomly, with i_mem_data and offset changed every cycle after capture -> output stable under stall, sequence identical to REQ-036, no beat lost or duplicated.
REQ-040 Scenario: i_rstn pulsed low for one cycle after beat 3 -> o_valid=0 and outputs 0 during reset; next capture (offset 0) streams words 1..16 cleanly.
REQ-041 Scenario: i_valid held 1 throughout a stream -> no capture until IDLE; second capture occurs in the cycle after the final transfer.
